// File: rtl/lim_inc.sv
// Limited incrementor digit: a + ci wrapping to 0 at limit L, with a registered copy.
// Optional saturating wrap counter enabled by defining LIM_INC_WRAP_CNT_EN.
module lim_inc #(
  parameter int unsigned L = 7,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co,
  output logic [W-1:0] sum_q,
  output logic         co_q
`ifdef LIM_INC_WRAP_CNT_EN
  ,
  output logic [15:0]  wrap_cnt
`endif
);

  // Limit held at W+1 bits so L == 2**W still compares correctly.
  localparam logic [W:0] Lim = (W+1)'(L);

  logic [W:0] s;

  always_comb begin
    s   = {1'b0, a} + {{W{1'b0}}, ci};
    sum = s[W-1:0];
    co  = 1'b0;
    // Covers out-of-range a as well: a >= L implies s >= L.
    if (s >= Lim) begin
      sum = '0;
      co  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum;
      co_q  <= co;
    end
  end

`ifdef LIM_INC_WRAP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_cnt <= '0;
    end else if (co && (wrap_cnt != 16'hFFFF)) begin
      wrap_cnt <= wrap_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lim_inc.sv
// Directed bench for lim_inc (L=7 and L=10 instances) with a per-cycle reference model.
// Checks wrap_cnt only when LIM_INC_WRAP_CNT_EN is defined.
module tb_lim_inc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, a10;
  logic       ci, ci10;
  logic [3:0] sum, sum_q, sum10, sum_q10;
  logic       co, co_q, co10, co_q10;
`ifdef LIM_INC_WRAP_CNT_EN
  logic [15:0] wrap_cnt, wrap_cnt10;
  int          exp_wc;
`endif

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  int exp_sum_q, exp_co_q, exp_sum_q10, exp_co_q10;

  always #5 clk = ~clk;

  lim_inc #(.L(7), .W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .ci    (ci),
    .sum   (sum),
    .co    (co),
    .sum_q (sum_q),
    .co_q  (co_q)
`ifdef LIM_INC_WRAP_CNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  lim_inc #(.L(10), .W(4)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a10),
    .ci    (ci10),
    .sum   (sum10),
    .co    (co10),
    .sum_q (sum_q10),
    .co_q  (co_q10)
`ifdef LIM_INC_WRAP_CNT_EN
    ,
    .wrap_cnt (wrap_cnt10)
`endif
  );

  // Reference: digit value after adding ci, wrapping to 0 at lim.
  function automatic int model_sum(int av, int cv, int lim);
    return (av + cv >= lim) ? 0 : av + cv;
  endfunction

  function automatic int model_co(int av, int cv, int lim);
    return (av + cv >= lim) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_sum_q   <= 0;
      exp_co_q    <= 0;
      exp_sum_q10 <= 0;
      exp_co_q10  <= 0;
    end else begin
      exp_sum_q   <= model_sum(int'(a), int'(ci), 7);
      exp_co_q    <= model_co(int'(a), int'(ci), 7);
      exp_sum_q10 <= model_sum(int'(a10), int'(ci10), 10);
      exp_co_q10  <= model_co(int'(a10), int'(ci10), 10);
    end
`ifdef LIM_INC_WRAP_CNT_EN
    if (!rst_n) exp_wc <= 0;
    else if (model_co(int'(a), int'(ci), 7) == 1 && exp_wc != 65535) exp_wc <= exp_wc + 1;
`endif
  end

  always @(negedge clk) begin
    if (run) begin
      check("cmp_sum",    32'(sum),     32'(model_sum(int'(a), int'(ci), 7)));
      check("cmp_co",     32'(co),      32'(model_co(int'(a), int'(ci), 7)));
      check("cmp_sum10",  32'(sum10),   32'(model_sum(int'(a10), int'(ci10), 10)));
      check("cmp_co10",   32'(co10),    32'(model_co(int'(a10), int'(ci10), 10)));
      check("cmp_sum_q",  32'(sum_q),   32'(exp_sum_q));
      check("cmp_co_q",   32'(co_q),    32'(exp_co_q));
      check("cmp_sum_q10", 32'(sum_q10), 32'(exp_sum_q10));
      check("cmp_co_q10", 32'(co_q10),  32'(exp_co_q10));
`ifdef LIM_INC_WRAP_CNT_EN
      check("cmp_wrap_cnt", 32'(wrap_cnt), 32'(exp_wc));
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    a     = 4'd3;
    ci    = 1'b1;
    a10   = 4'd8;
    ci10  = 1'b1;

    // Reset held for two edges: registered outputs cleared, combinational path live.
    @(posedge clk); #1;
    run = 1'b1;
    check("rst1_sum_q", 32'(sum_q), 32'd0);
    check("rst1_co_q",  32'(co_q),  32'd0);
    check("rst1_sum",   32'(sum),   32'd4);
    @(posedge clk); #1;
    check("rst2_sum_q", 32'(sum_q), 32'd0);
    check("rst2_co_q",  32'(co_q),  32'd0);
    check("rst2_sum",   32'(sum),   32'd4);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_sum_q", 32'(sum_q), 32'd4);
    check("post_rst_co_q",  32'(co_q),  32'd0);

    // Boundary values around the L=7 limit.
    a = 4'd6; ci = 1'b1; #1;
    check("a6c1_sum", 32'(sum), 32'd0);
    check("a6c1_co",  32'(co),  32'd1);
    a = 4'd5; ci = 1'b1; #1;
    check("a5c1_sum", 32'(sum), 32'd6);
    check("a5c1_co",  32'(co),  32'd0);
    a = 4'd6; ci = 1'b0; #1;
    check("a6c0_sum", 32'(sum), 32'd6);
    check("a6c0_co",  32'(co),  32'd0);
    a = 4'd15; ci = 1'b1; #1;
    check("a15c1_sum", 32'(sum), 32'd0);
    check("a15c1_co",  32'(co),  32'd1);

    @(posedge clk); #1;
    // L=10 boundary.
    a10 = 4'd9; ci10 = 1'b1; #1;
    check("l10_a9_sum", 32'(sum10), 32'd0);
    check("l10_a9_co",  32'(co10),  32'd1);
    a10 = 4'd8; ci10 = 1'b1; #1;
    check("l10_a8_sum", 32'(sum10), 32'd9);
    check("l10_a8_co",  32'(co10),  32'd0);

    // Registered wrap appears one edge after the inputs apply.
    @(posedge clk); #1;
    a = 4'd6; ci = 1'b1;
    @(posedge clk); #1;
    check("reg_wrap_co_q",  32'(co_q),  32'd1);
    check("reg_wrap_sum_q", 32'(sum_q), 32'd0);

    // Exhaustive sweep on both instances.
    for (int ai = 0; ai < 16; ai++) begin
      for (int c = 0; c < 2; c++) begin
        a = 4'(ai); ci = 1'(c); a10 = 4'(ai); ci10 = 1'(c);
        @(posedge clk); #1;
        check("exh_sum_q", 32'(sum_q), 32'((ai + c >= 7) ? 0 : ai + c));
        check("exh_co_q",  32'(co_q),  32'((ai + c >= 7) ? 1 : 0));
      end
    end

`ifdef LIM_INC_WRAP_CNT_EN
    rst_n = 1'b0; a = 4'd6; ci = 1'b1;
    @(posedge clk); #1;
    check("wc_rst", 32'(wrap_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("wc_five", 32'(wrap_cnt), 32'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("wc_clear", 32'(wrap_cnt), 32'd0);
    rst_n = 1'b1;
`endif

    @(posedge clk); #1;
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
